bcd_countdown_timer: RTL and testbench

Multi-digit BCD countdown timer that generalises the single-digit down counter into a parametrised N-digit chain with load, start/stop/pause control, an expiry state machine and auto-restart from the last loaded value. It sits between the prescaler that produces the one-cycle `tick` strobe and the seven-segment display driver, which consumes the packed BCD digits.

---
 rtl/bcd_countdown_timer.sv | 137 +++++++++++++
 tb/tb_bcd_countdown_timer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - N-digit BCD countdown timer with load, start/stop/pause and auto-restart
// Optional feature macro: BLANK_ON_EXPIRE_EN (blank all digits to 4'hF while EXPIRED).
module bcd_countdown_timer #(
    parameter int                  DIGITS = 4,
    parameter logic [4*DIGITS-1:0] INIT   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  stop,
    output logic [4*DIGITS-1:0]   digits,
    output logic [1:0]            state,
    output logic                  done
);

    localparam int W = 4 * DIGITS;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUN     = 2'b01;
    localparam logic [1:0] ST_PAUSED  = 2'b10;
    localparam logic [1:0] ST_EXPIRED = 2'b11;

    logic [W-1:0] count_q,  count_d;
    logic [W-1:0] reload_q, reload_d;
    logic [W-1:0] digits_q, digits_d;
    logic [1:0]   state_q,  state_d;
    logic         done_q,   done_d;
    logic [W-1:0] count_dec;

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Ripple borrow: a zero digit wraps to 9 and passes the borrow upward.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign count_dec = bcd_dec(count_q);

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        state_d  = state_q;
        done_d   = 1'b0;
        if (load) begin
            count_d  = bcd_clamp(load_value);
            reload_d = bcd_clamp(load_value);
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!stop && start) begin
                        if (count_q == '0) begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_PAUSED;
                    end else if (tick) begin
                        count_d = count_dec;
                        if (count_dec == '0) begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!stop && start) state_d = ST_RUN;
                end
                default: begin
                    if (!stop && start) begin
                        count_d = reload_q;
                        if (reload_q == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
            endcase
        end
`ifdef BLANK_ON_EXPIRE_EN
        digits_d = (state_d == ST_EXPIRED) ? {DIGITS{4'hF}} : count_d;
`else
        digits_d = count_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= INIT;
            reload_q <= INIT;
            digits_q <= INIT;
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            digits_q <= digits_d;
            state_q  <= state_d;
            done_q   <= done_d;
        end
    end

    assign digits = digits_q;
    assign state  = state_q;
    assign done   = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed self-checking bench for bcd_countdown_timer (DIGITS=4)
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        reset, tick, load, start, stop;
    logic [15:0] load_value;
    logic [15:0] digits;
    logic [1:0]  state;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef BLANK_ON_EXPIRE_EN
    localparam logic [15:0] EXP_DIG = 16'hFFFF;
`else
    localparam logic [15:0] EXP_DIG = 16'h0000;
`endif

    bcd_countdown_timer #(.DIGITS(4), .INIT(16'h0000)) dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load),
        .load_value(load_value), .start(start), .stop(stop),
        .digits(digits), .state(state), .done(done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
        reset = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [15:0] d, input logic [1:0] s, input logic dn);
        chk({tag, ".digits"}, digits, d);
        chk({tag, ".state"}, {14'd0, state}, {14'd0, s});
        chk({tag, ".done"}, {15'd0, done}, {15'd0, dn});
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
        load_value = 16'h0000;
        cyc();
        chk3("reset", 16'h0000, 2'b00, 1'b0);

        // start at zero in IDLE expires immediately; start again with reload=0 pulses again
        start = 1'b1; cyc();
        chk3("idle_start_zero", EXP_DIG, 2'b11, 1'b1);
        cyc();
        chk3("expired_hold", EXP_DIG, 2'b11, 1'b0);
        start = 1'b1; cyc();
        chk3("restart_reload0", EXP_DIG, 2'b11, 1'b1);

        // basic countdown with borrow
        load = 1'b1; load_value = 16'h0102; cyc();
        chk3("load0102", 16'h0102, 2'b00, 1'b0);
        tick = 1'b1; cyc();
        chk3("idle_tick_ignored", 16'h0102, 2'b00, 1'b0);
        start = 1'b1; cyc();
        chk3("start", 16'h0102, 2'b01, 1'b0);
        tick = 1'b1; cyc(); chk3("t1", 16'h0101, 2'b01, 1'b0);
        tick = 1'b1; cyc(); chk3("t2", 16'h0100, 2'b01, 1'b0);
        tick = 1'b1; cyc(); chk3("t3", 16'h0099, 2'b01, 1'b0);

        // expiry
        load = 1'b1; load_value = 16'h0002; cyc();
        start = 1'b1; cyc();
        tick = 1'b1; cyc(); chk3("e1", 16'h0001, 2'b01, 1'b0);
        tick = 1'b1; cyc(); chk3("e0", EXP_DIG, 2'b11, 1'b1);
        cyc();              chk3("e_done_once", EXP_DIG, 2'b11, 1'b0);
        tick = 1'b1; cyc(); chk3("e_tick_hold", EXP_DIG, 2'b11, 1'b0);

        // pause: stop beats tick
        load = 1'b1; load_value = 16'h0005; cyc();
        start = 1'b1; cyc();
        tick = 1'b1; stop = 1'b1; cyc(); chk3("pause", 16'h0005, 2'b10, 1'b0);
        tick = 1'b1; cyc(); chk3("paused_tick", 16'h0005, 2'b10, 1'b0);
        start = 1'b1; cyc(); chk3("resume", 16'h0005, 2'b01, 1'b0);
        tick = 1'b1; cyc(); chk3("resume_tick", 16'h0004, 2'b01, 1'b0);

        // clamp, run to expiry, auto-restart
        load = 1'b1; load_value = 16'h00AF; cyc();
        chk3("clamp", 16'h0099, 2'b00, 1'b0);
        start = 1'b1; cyc();
        for (int i = 0; i < 98; i++) begin
            tick = 1'b1; cyc();
        end
        chk3("run98", 16'h0001, 2'b01, 1'b0);
        tick = 1'b1; cyc(); chk3("run99", EXP_DIG, 2'b11, 1'b1);
        start = 1'b1; cyc(); chk3("autorestart", 16'h0099, 2'b01, 1'b0);

        // load beats stop and tick
        load = 1'b1; load_value = 16'h0050; cyc();
        start = 1'b1; cyc();
        load = 1'b1; load_value = 16'h0300; stop = 1'b1; tick = 1'b1; cyc();
        chk3("load_prio", 16'h0300, 2'b00, 1'b0);
        start = 1'b1; cyc();
        tick = 1'b1; cyc(); chk3("borrow3", 16'h0299, 2'b01, 1'b0);
        reset = 1'b1; tick = 1'b1; cyc();
        chk3("reset_mid_run", 16'h0000, 2'b00, 1'b0);

        // expire from 0001 then reload
        load = 1'b1; load_value = 16'h0001; cyc();
        start = 1'b1; cyc();
        tick = 1'b1; cyc(); chk3("exp1", EXP_DIG, 2'b11, 1'b1);
        load = 1'b1; load_value = 16'h0007; cyc();
        chk3("load7", 16'h0007, 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
